// File: rtl/vslc_pkg.sv
// Shared definitions for the VSLC scan sequencer and its executor.
//   - Default program-store geometry (depth and address width).
//   - Sequencer FSM state encoding.
//   - Executor opcode field positions within an 8-bit instruction.
package vslc_pkg;

    localparam int unsigned PROG_DEPTH_DEF = 16;
    localparam int unsigned AW_DEF         = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StSnap  = 2'd2,
        StIssue = 2'd3
    } seq_state_e;

    // Executor instruction layout: two-bit opcode over a six-bit operand.
    localparam int unsigned OP_MSB  = 7;
    localparam int unsigned OP_LSB  = 6;
    localparam int unsigned ARG_MSB = 5;
    localparam int unsigned ARG_LSB = 0;

endpackage

// File: rtl/tt_um_jimktrains_vslc_progmem.sv
// Program store for the VSLC sequencer.
// One synchronous write port and one asynchronous read port; the array has no
// reset, so its contents are undefined until a program is loaded.
// Ports:
//   clk      - write clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data (one program byte)
//   i_raddr  - read address
//   o_rdata  - read data, combinational from i_raddr
module tt_um_jimktrains_vslc_progmem
    import vslc_pkg::*;
#(
    parameter int unsigned DEPTH = PROG_DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tt_um_jimktrains_vslc_sequencer.sv
// VSLC scan sequencer.
// Loads a byte program, then repeatedly scans it: one SNAP cycle freezes the
// raw inputs, followed by one ISSUE cycle per program byte.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   load_en      - program-load mode request
//   load_valid   - one-cycle strobe qualifying load_data
//   load_data    - program byte
//   run          - continuous scan request
//   ui_in        - raw inputs
//   instr        - instruction to executor (8'h00 when not issuing)
//   instr_ready  - instr valid this cycle
//   ui_snap      - inputs frozen for the current scan
//   ui_in_prev   - ui_snap of the previous scan
//   scan_done    - one-cycle pulse after the last instruction of a scan
//   running      - high in SNAP or ISSUE
//   load_ovf     - sticky: a byte was dropped because the store was full
//   pc           - program counter
module tt_um_jimktrains_vslc_sequencer
    import vslc_pkg::*;
#(
    parameter int unsigned PROG_DEPTH = PROG_DEPTH_DEF,
    parameter int unsigned AW         = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    input  logic          run,
    input  logic [7:0]    ui_in,
    output logic [7:0]    instr,
    output logic          instr_ready,
    output logic [7:0]    ui_snap,
    output logic [7:0]    ui_in_prev,
    output logic          scan_done,
    output logic          running,
    output logic          load_ovf,
    output logic [AW-1:0] pc
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(PROG_DEPTH);

    seq_state_e  r_state, w_state_d;
    logic [AW-1:0] r_pc, w_pc_d;
    // Pointer and length are one bit wider so a full store is representable.
    logic [AW:0] r_wr_ptr, w_wr_ptr_d;
    logic [AW:0] r_prog_len, w_prog_len_d;
    logic [7:0]  r_ui_snap, w_ui_snap_d;
    logic [7:0]  r_ui_in_prev, w_ui_in_prev_d;
    logic        r_load_ovf, w_load_ovf_d;
    logic        r_scan_done, w_scan_done_d;

    logic        w_mem_we;
    logic [7:0]  w_mem_rdata;
    logic        w_last_instr;
    logic        w_store_full;

    assign w_last_instr = ({1'b0, r_pc} == (r_prog_len - (AW+1)'(1)));
    assign w_store_full = (r_wr_ptr == DEPTH_CNT);

    tt_um_jimktrains_vslc_progmem #(
        .DEPTH (PROG_DEPTH),
        .AW    (AW)
    ) u_progmem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (load_data),
        .i_raddr (r_pc),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        w_state_d      = r_state;
        w_pc_d         = r_pc;
        w_wr_ptr_d     = r_wr_ptr;
        w_prog_len_d   = r_prog_len;
        w_ui_snap_d    = r_ui_snap;
        w_ui_in_prev_d = r_ui_in_prev;
        w_load_ovf_d   = r_load_ovf;
        w_scan_done_d  = 1'b0;
        w_mem_we       = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (load_en) begin
                    w_state_d = StLoad;
                end else if (run && (r_prog_len != '0)) begin
                    w_state_d = StSnap;
                end
            end
            StLoad: begin
                if (!load_en) begin
                    w_prog_len_d = r_wr_ptr;
                    w_state_d    = StIdle;
                end else if (load_valid) begin
                    if (w_store_full) begin
                        w_load_ovf_d = 1'b1;
                    end else begin
                        w_mem_we   = 1'b1;
                        w_wr_ptr_d = r_wr_ptr + (AW+1)'(1);
                    end
                end
            end
            StSnap: begin
                w_ui_in_prev_d = r_ui_snap;
                w_ui_snap_d    = ui_in;
                w_pc_d         = '0;
                w_state_d      = StIssue;
            end
            StIssue: begin
                if (!w_last_instr) begin
                    // load_en abandons the rest of the scan without scan_done.
                    if (load_en) begin
                        w_state_d = StLoad;
                    end else begin
                        w_pc_d = r_pc + AW'(1);
                    end
                end else begin
                    w_scan_done_d = 1'b1;
                    if (load_en) begin
                        w_state_d = StLoad;
                    end else if (run) begin
                        w_state_d = StSnap;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
        endcase

        // Every entry into LOAD starts a fresh program.
        if ((w_state_d == StLoad) && (r_state != StLoad)) begin
            w_wr_ptr_d   = '0;
            w_load_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_pc         <= '0;
            r_wr_ptr     <= '0;
            r_prog_len   <= '0;
            r_ui_snap    <= '0;
            r_ui_in_prev <= '0;
            r_load_ovf   <= 1'b0;
            r_scan_done  <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_pc         <= w_pc_d;
            r_wr_ptr     <= w_wr_ptr_d;
            r_prog_len   <= w_prog_len_d;
            r_ui_snap    <= w_ui_snap_d;
            r_ui_in_prev <= w_ui_in_prev_d;
            r_load_ovf   <= w_load_ovf_d;
            r_scan_done  <= w_scan_done_d;
        end
    end

    // Outputs decode only registered state; the executor samples on negedge.
    assign instr_ready = (r_state == StIssue);
    assign instr       = instr_ready ? w_mem_rdata : 8'h00;
    assign running     = (r_state == StSnap) || (r_state == StIssue);
    assign ui_snap     = r_ui_snap;
    assign ui_in_prev  = r_ui_in_prev;
    assign scan_done   = r_scan_done;
    assign load_ovf    = r_load_ovf;
    assign pc          = r_pc;

endmodule
